// File: rtl/alarm_ctrl_pkg.sv
// Shared encodings and widths for the safe-box alarm controller.
package alarm_ctrl_pkg;

    localparam int unsigned FAIL_CNT_W = 3;
    localparam int unsigned STATE_W    = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_WARN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_ALARM = 2'd2;
    localparam logic [STATE_W-1:0] ST_LOCK  = 2'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_ctrl_tick_timer.sv
// Prescaled tick timer: done is high in the last cycle of ticks*TICK_DIV cycles after start.
module tick_timer #(
    parameter int unsigned TICK_DIV = 8000,
    parameter int unsigned TICKS_W  = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TICKS_W-1:0] ticks,
    output logic               done
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic [TICKS_W-1:0] tick;
    logic               presc_wrap;
    logic               tick_last;

    assign presc_wrap = (presc == PRESC_LAST);
    assign tick_last  = (tick >= ticks - TICKS_W'(1));
    // Combinational from the counters so the owner can leave on exactly the final edge.
    assign done       = presc_wrap && tick_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= '0;
        end else if (start) begin
            presc <= '0;
            tick  <= '0;
        end else if (presc_wrap) begin
            presc <= '0;
            tick  <= tick_last ? '0 : tick + TICKS_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/alarm_ctrl.sv
// Safe-box intrusion controller: counts bad codes, sequences ALARM then LOCK.
// Optional LOCK phase built only when ALARM_CTRL_LOCK_EN is defined.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned TICK_DIV    = 8000,
    parameter int unsigned ALARM_TICKS = 2000,
    parameter int unsigned LOCK_TICKS  = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  attempt_valid,
    input  logic                  attempt_ok,
    input  logic                  admin_clear,
    output logic                  alarm,
    output logic                  locked,
    output logic                  open_pulse,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
    output logic [STATE_W-1:0]    state
);

    localparam int unsigned TICKS_W = $clog2(max_u(ALARM_TICKS, LOCK_TICKS) + 1);
    localparam logic [FAIL_CNT_W-1:0] MAX_C = FAIL_CNT_W'(MAX_FAILS);

    logic [STATE_W-1:0]    state_nxt;
    logic [FAIL_CNT_W-1:0] cnt_nxt;
    logic [FAIL_CNT_W-1:0] fail_inc;
    logic                  pulse_nxt;
    logic                  tmr_start;
    logic                  tmr_done;
    logic [TICKS_W-1:0]    ticks_sel;

    assign fail_inc = (fail_cnt >= MAX_C) ? MAX_C : fail_cnt + FAIL_CNT_W'(1);

    always_comb begin
        ticks_sel = TICKS_W'(ALARM_TICKS);
`ifdef ALARM_CTRL_LOCK_EN
        if (state == ST_LOCK) ticks_sel = TICKS_W'(LOCK_TICKS);
`endif
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = fail_cnt;
        pulse_nxt = 1'b0;
        tmr_start = 1'b0;
        if (admin_clear) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            tmr_start = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_WARN: begin
                    if (attempt_valid) begin
                        if (attempt_ok) begin
                            pulse_nxt = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            cnt_nxt = fail_inc;
                            if (fail_inc == MAX_C) begin
                                state_nxt = ST_ALARM;
                                tmr_start = 1'b1;
                            end else begin
                                state_nxt = ST_WARN;
                            end
                        end
                    end
                end
                ST_ALARM: begin
                    if (tmr_done) begin
`ifdef ALARM_CTRL_LOCK_EN
                        state_nxt = ST_LOCK;
                        tmr_start = 1'b1;
`else
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
`endif
                    end
                end
`ifdef ALARM_CTRL_LOCK_EN
                ST_LOCK: begin
                    if (tmr_done) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            fail_cnt   <= '0;
            open_pulse <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_nxt;
            fail_cnt   <= cnt_nxt;
            open_pulse <= pulse_nxt;
            alarm      <= (state_nxt == ST_ALARM);
        end
    end

`ifdef ALARM_CTRL_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) locked <= 1'b0;
        else        locked <= (state_nxt == ST_ALARM) || (state_nxt == ST_LOCK);
    end
`else
    assign locked = alarm;
`endif

    tick_timer #(
        .TICK_DIV (TICK_DIV),
        .TICKS_W  (TICKS_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tmr_start),
        .ticks (ticks_sel),
        .done  (tmr_done)
    );

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: expected output changes and their hold times are queued.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       attempt_valid = 1'b0;
    logic       attempt_ok = 1'b0;
    logic       admin_clear = 1'b0;
    logic       alarm, locked, open_pulse;
    logic [2:0] fail_cnt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

`ifdef ALARM_CTRL_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    typedef struct {
        logic [7:0] tup;
        int         dur;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alarm_ctrl #(
        .MAX_FAILS   (3),
        .TICK_DIV    (4),
        .ALARM_TICKS (3),
        .LOCK_TICKS  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .attempt_valid (attempt_valid),
        .attempt_ok    (attempt_ok),
        .admin_clear   (admin_clear),
        .alarm         (alarm),
        .locked        (locked),
        .open_pulse    (open_pulse),
        .fail_cnt      (fail_cnt),
        .state         (state)
    );

    function automatic logic [7:0] tp(input logic [1:0] st, input logic [2:0] c,
                                      input logic al, input logic lk, input logic op);
        return {st, c, al, lk, op};
    endfunction

    task automatic expect_ev(input logic [7:0] t, input int d);
        exp_t e;
        e.tup = t;
        e.dur = d;
        sb.push_back(e);
    endtask

    task automatic attempt(input logic ok);
        attempt_valid = 1'b1;
        attempt_ok    = ok;
        @(negedge clk);
        attempt_valid = 1'b0;
        attempt_ok    = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change of the output tuple is popped and compared, with its predecessor's hold time.
    logic [7:0] prev = 8'hFF;
    int         hold = 0;
    always @(negedge clk) begin
        logic [7:0] cur;
        exp_t       e;
        cur = {state, fail_cnt, alarm, locked, open_pulse};
`ifndef ALARM_CTRL_LOCK_EN
        checks++;
        if (locked !== alarm) begin
            errors++;
            $display("FAIL locked_eq_alarm got locked=%b alarm=%b", locked, alarm);
        end
`endif
        if (cur !== prev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got=%h hold=%0d", cur, hold);
            end else begin
                e = sb.pop_front();
                if (e.tup !== cur || (e.dur != 0 && e.dur != hold)) begin
                    errors++;
                    $display("FAIL event got=%h exp=%h prev_hold=%0d exp_hold=%0d",
                             cur, e.tup, hold, e.dur);
                end
            end
            prev = cur;
            hold = 1;
        end else begin
            hold++;
        end
    end

    initial begin
        expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Three bad attempts 5 cycles apart
        expect_ev(tp(2'd1, 3'd1, 0, 0, 0), 0);
        expect_ev(tp(2'd1, 3'd2, 0, 0, 0), 5);
        expect_ev(tp(2'd2, 3'd3, 1, 1, 0), 5);
        if (LK) begin
            expect_ev(tp(2'd3, 3'd3, 0, 1, 0), 12);
            expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 8);
        end else begin
            expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 12);
        end
        attempt(1'b0); gap(4);
        attempt(1'b0); gap(4);
        attempt(1'b0); gap(25);

        // Two bad then one good
        expect_ev(tp(2'd1, 3'd1, 0, 0, 0), 0);
        expect_ev(tp(2'd1, 3'd2, 0, 0, 0), 3);
        expect_ev(tp(2'd0, 3'd0, 0, 0, 1), 3);
        expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 1);
        attempt(1'b0); gap(2);
        attempt(1'b0); gap(2);
        attempt(1'b1); gap(3);

        // Attempts during ALARM and LOCK are ignored and do not stretch either phase
        expect_ev(tp(2'd1, 3'd1, 0, 0, 0), 0);
        expect_ev(tp(2'd1, 3'd2, 0, 0, 0), 2);
        expect_ev(tp(2'd2, 3'd3, 1, 1, 0), 2);
        if (LK) begin
            expect_ev(tp(2'd3, 3'd3, 0, 1, 0), 12);
            expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 8);
        end else begin
            expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 12);
        end
        attempt(1'b0); gap(1);
        attempt(1'b0); gap(1);
        attempt(1'b0); gap(3);
        attempt(1'b1); gap(2);
        attempt(1'b0);
        if (LK) begin
            gap(6);
            attempt(1'b1); gap(2);
            attempt(1'b0); gap(10);
        end else begin
            gap(16);
        end

        // admin_clear wins over a simultaneous good attempt in WARN
        expect_ev(tp(2'd1, 3'd1, 0, 0, 0), 0);
        expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 3);
        attempt(1'b0); gap(2);
        admin_clear = 1'b1;
        attempt(1'b1);
        admin_clear = 1'b0;
        gap(3);

        // Back-to-back bad attempts, then reset 5 cycles into ALARM
        expect_ev(tp(2'd1, 3'd1, 0, 0, 0), 0);
        expect_ev(tp(2'd1, 3'd2, 0, 0, 0), 1);
        expect_ev(tp(2'd2, 3'd3, 1, 1, 0), 1);
        expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 5);
        attempt(1'b0);
        attempt(1'b0);
        attempt(1'b0);
        gap(4);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (alarm !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got alarm=%b locked=%b exp 0 0", alarm, locked);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        expect_ev(tp(2'd1, 3'd1, 0, 0, 0), 2);
        expect_ev(tp(2'd0, 3'd0, 0, 0, 1), 2);
        expect_ev(tp(2'd0, 3'd0, 0, 0, 0), 1);
        attempt(1'b0); gap(1);
        attempt(1'b1); gap(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
